// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
// Issues single-outstanding fetches, absorbs memory latency, decode stalls
// and redirects, and presents a registered instruction word plus its PC.
// Optional build macro: IF_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_inst;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;

  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_release;
  logic        w_load;

  assign w_pc4     = r_pc + 32'd4;
  assign w_target  = {redirect_pc[31:2], 2'b00};
  // An instruction enters IF/ID either straight from memory or from the hold buffer.
  assign w_accept  = (r_state == S_WAIT) && imem_rvalid && !redirect_valid && !stall;
  assign w_release = (r_state == S_HOLD) && !redirect_valid && !stall;
  assign w_load    = w_accept || w_release;

  // The follow-on request goes out in the same cycle as the load so a
  // 1-cycle memory sustains one instruction per clock; the PC register
  // still points at the word being loaded, hence pc+4 on the bus.
  assign imem_req  = !RST && !redirect_valid && ((r_state == S_FETCH) || w_load);
  assign imem_addr = (r_state == S_FETCH) ? r_pc : w_pc4;

  assign ifid_valid = r_ifid_valid;
  assign ifid_inst  = r_ifid_inst;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;

  // Fetch FSM, PC, hold buffer and IF/ID register; redirect outranks stall and rvalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_hold       <= NOP_INST;
      r_ifid_valid <= 1'b0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
    end else if (redirect_valid) begin
      r_pc         <= w_target;
      r_ifid_valid <= 1'b0;
      r_ifid_inst  <= NOP_INST;
      // A request still in flight must be swallowed before refetching.
      if (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rvalid) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              r_hold  <= imem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_pc <= w_pc4;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_pc    <= w_pc4;
            r_state <= S_WAIT;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
      // Without a stall decode consumes IF/ID each cycle; no new word means a bubble.
      if (!stall) begin
        r_ifid_valid <= w_load;
        if (w_accept) begin
          r_ifid_inst <= imem_rdata;
        end else if (w_release) begin
          r_ifid_inst <= r_hold;
        end else begin
          r_ifid_inst <= NOP_INST;
        end
        if (w_load) begin
          r_ifid_pc  <= r_pc;
          r_ifid_pc4 <= w_pc4;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;

  // Performance counters; only RST clears them, redirects leave them alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_load) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (stall && r_ifid_valid) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a long
// randomized run against a program-order reference model with a
// variable-latency instruction memory.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  if_stage #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .ifid_valid(ifid_valid),
    .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Stimulus controls
  logic        drv_rst = 1'b1;
  logic        drv_stall = 1'b0;
  logic        drv_redir = 1'b0;
  logic [31:0] drv_target = '0;

  // Memory model
  int unsigned lat = 1;
  bit          lat_rand = 1'b0;
  logic [31:0] mem_scr = '0;
  bit          mem_pending = 1'b0;
  bit          mem_orphan = 1'b0;
  logic [31:0] mem_addr = '0;
  int unsigned mem_cnt = 0;

  // Reference model
  bit          prev_rst = 1'b1;
  bit          prev_stall = 1'b0;
  bit          prev_redir = 1'b0;
  logic        s_valid, p_valid;
  logic [31:0] s_inst, s_pc, s_pc4, p_inst, p_pc, p_pc4;
  logic        obs_req;
  logic [31:0] obs_addr;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  int unsigned delivered = 0;
  int unsigned exp_pstall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ mem_scr;
  endfunction

  // One clock: check registered outputs, drive inputs, check the request, update the model.
  task automatic tick();
    logic        rv;
    logic [31:0] rd;
    @(negedge CLK);
    s_valid = ifid_valid;
    s_inst  = ifid_inst;
    s_pc    = ifid_pc;
    s_pc4   = ifid_pc4;
    if (prev_rst) begin
      chk("rst_valid", {31'b0, s_valid}, 32'd0);
      chk("rst_inst", s_inst, NOP);
      chk("rst_pc", s_pc, 32'd0);
      chk("rst_pc4", s_pc4, 32'd0);
    end else if (prev_redir) begin
      chk("flush_valid", {31'b0, s_valid}, 32'd0);
      chk("flush_inst", s_inst, NOP);
    end else if (prev_stall) begin
      chk("hold_valid", {31'b0, s_valid}, {31'b0, p_valid});
      chk("hold_inst", s_inst, p_inst);
      chk("hold_pc", s_pc, p_pc);
      chk("hold_pc4", s_pc4, p_pc4);
    end else if (s_valid) begin
      chk("deliv_pc", s_pc, exp_pc);
      chk("deliv_inst", s_inst, word_at(exp_pc));
      chk("deliv_pc4", s_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else begin
      chk("bubble_inst", s_inst, NOP);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, delivered);
    chk("perf_stall", perf_stall, exp_pstall);
`endif
    p_valid = s_valid;
    p_inst  = s_inst;
    p_pc    = s_pc;
    p_pc4   = s_pc4;

    rv = 1'b0;
    rd = $urandom;
    if (mem_pending) begin
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = mem_orphan ? 32'hDEAD_BEEF : word_at(mem_addr);
        mem_pending = 1'b0;
        mem_orphan  = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    RST            = drv_rst;
    stall          = drv_stall;
    redirect_valid = drv_redir;
    redirect_pc    = drv_target;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;

    if (drv_rst) begin
      chk("req_in_reset", {31'b0, obs_req}, 32'd0);
    end else if (drv_redir) begin
      chk("req_on_redirect", {31'b0, obs_req}, 32'd0);
    end else begin
      if (mem_pending) chk("req_outstanding", {31'b0, obs_req}, 32'd0);
      if (obs_req) begin
        chk("req_addr", obs_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
    end
    if (obs_req && !drv_rst) begin
      mem_pending = 1'b1;
      mem_addr    = obs_addr;
      mem_cnt     = lat_rand ? $urandom_range(0, 3) : lat - 1;
    end
    if (!drv_rst && drv_stall && s_valid) exp_pstall++;
    if (drv_rst) begin
      exp_pc     = RESET_PC;
      exp_req    = RESET_PC;
      delivered  = 0;
      exp_pstall = 0;
    end else if (drv_redir) begin
      exp_pc  = {drv_target[31:2], 2'b00};
      exp_req = {drv_target[31:2], 2'b00};
    end
    prev_rst   = drv_rst;
    prev_redir = drv_redir;
    prev_stall = drv_stall;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    drv_stall = 1'b0;
    drv_redir = 1'b0;
    lat_rand = 1'b0;
    mem_pending = 1'b0;
    mem_orphan = 1'b0;
    tick();
    tick();
    drv_rst = 1'b0;
  endtask

  // Single reset cycle; the outstanding response lands right after reset releases.
  task automatic do_reset_late();
    drv_rst = 1'b1;
    if (mem_pending) begin
      mem_cnt = 1;
      mem_orphan = 1'b1;
    end
    tick();
    drv_rst = 1'b0;
  endtask

  initial begin
    int unsigned n;
    RST = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;

    // 1-cycle memory, word = address
    mem_scr = '0;
    lat = 1;
    do_reset();
    tick(); chk("t1_req", {31'b0, obs_req}, 32'd1); chk("t1_addr0", obs_addr, 32'h0);
    tick(); chk("t1_addr1", obs_addr, 32'h4);
    tick(); chk("t1_addr2", obs_addr, 32'h8);
    chk("t1_valid3", {31'b0, s_valid}, 32'd1); chk("t1_inst0", s_inst, 32'h0);
    tick(); chk("t1_addr3", obs_addr, 32'hC); chk("t1_inst1", s_inst, 32'h4);
    tick(); chk("t1_inst2", s_inst, 32'h8);

    // 3-cycle memory: one request every three cycles
    lat = 3;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (obs_req) n++;
    end
    chk("t2_req_count", n, 32'd3);

    // Stall across the 0x10 response
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("t3_addr10", obs_addr, 32'h10);
    drv_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_noreq", {31'b0, obs_req}, 32'd0);
      chk("t3_hold_pc", s_pc, 32'hC);
    end
    drv_stall = 1'b0;
    tick();
    chk("t3_req_rel", {31'b0, obs_req}, 32'd1);
    chk("t3_addr14", obs_addr, 32'h14);
    chk("t3_pc_still", s_pc, 32'hC);
    tick();
    chk("t3_pc10", s_pc, 32'h10);
    chk("t3_inst10", s_inst, 32'h10);

    // Redirect while a 2-cycle fetch of 0x08 is outstanding
    lat = 1;
    do_reset();
    tick(); tick();
    lat = 2;
    tick();
    chk("t4_addr8", obs_addr, 32'h8);
    drv_redir = 1'b1; drv_target = 32'h203;
    tick();
    drv_redir = 1'b0;
    tick();
    chk("t4_drop_noreq", {31'b0, obs_req}, 32'd0);
    tick();
    chk("t4_addr200", obs_addr, 32'h200);
    chk("t4_valid_lo", {31'b0, s_valid}, 32'd0);
    tick(); tick();
    chk("t4_nop", s_inst, NOP);
    tick();
    chk("t4_valid_hi", {31'b0, s_valid}, 32'd1);
    chk("t4_pc200", s_pc, 32'h200);
    chk("t4_inst200", s_inst, 32'h200);

    // Redirect and stall together flush a valid IF/ID
    lat = 1;
    do_reset();
    tick(); tick();
    drv_stall = 1'b1; drv_redir = 1'b1; drv_target = 32'h100;
    tick();
    chk("t5_pre_valid", {31'b0, s_valid}, 32'd1);
    drv_stall = 1'b0; drv_redir = 1'b0;
    tick();
    chk("t5_valid", {31'b0, s_valid}, 32'd0);
    chk("t5_inst", s_inst, NOP);
    chk("t5_addr", obs_addr, 32'h100);

    // Reset while waiting, stale response arrives just after reset
    lat = 5;
    do_reset();
    tick(); tick();
    do_reset_late();
    tick();
    chk("t6_rvalid_seen", {31'b0, imem_rvalid}, 32'd1);
    chk("t6_req", {31'b0, obs_req}, 32'd1);
    chk("t6_addr", obs_addr, RESET_PC);
    tick();
    chk("t6_ignored", {31'b0, s_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("t6_perf", perf_fetched, 32'd0);
`endif
    for (int i = 0; i < 5; i++) tick();
    chk("t6_first_valid", {31'b0, s_valid}, 32'd1);
    chk("t6_first_inst", s_inst, word_at(RESET_PC));

    // PC wrap at the top of the address space
    lat = 1;
    do_reset();
    tick();
    drv_redir = 1'b1; drv_target = 32'hFFFF_FFF8;
    tick();
    drv_redir = 1'b0;
    tick(); chk("t7_addr_f8", obs_addr, 32'hFFFF_FFF8);
    tick(); chk("t7_addr_fc", obs_addr, 32'hFFFF_FFFC);
    tick(); chk("t7_addr_wrap", obs_addr, 32'h0);
    tick(); chk("t7_pc_fc", s_pc, 32'hFFFF_FFFC); chk("t7_pc4_wrap", s_pc4, 32'h0);

    // Randomized latency, stalls and redirects
    do_reset();
    mem_scr = $urandom;
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_redir = ($urandom_range(0, 19) == 0);
      drv_target = $urandom;
      if ($urandom_range(0, 3) == 0) drv_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      tick();
    end
    drv_stall = 1'b0;
    drv_redir = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("rand_progress", {31'b0, (delivered > 20)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
